fire_scheduler: RTL and testbench
=================================

Name: fire_scheduler

Overview:
- Sequences one imaging line: up to four focal-zone firings, each split into prepare, transmit/receive, listen and end windows.
- Drives Pr_Gate, RX_Gate, End_Gate, Focus_Num and Line_Num to Transmit and Receive.
- Replaces the free-running pulse counter and ad-hoc focus/idle logic in the top level.
- Sits in the CLK_100M domain, triggered by a pre-synchronised Envelop edge pulse.

Parameters:
- CW, 32: width of the phase and idle counters.
- PR_CYCLES, 3000: Pr_Gate window length, 30 us.
- RX_CYCLES, 250: RX_Gate window length, 2.5 us.
- END_CYCLES, 80: End_Gate window length, 0.8 us.
- PERIOD0 / PERIOD1 / PERIOD2 / PERIOD3, 9000 / 12000 / 18000 / 18000: total firing period per focal zone, measured from PREP entry.
- IDLE_CYCLES, 50000000: Enable hold time after the last Line_Req, 0.5 s.

Ports:
- CLK_100M  in  1  system clock, 100 MHz.
- RST_n  in  1  reset, synchronous, active-low.
- Line_Req  in  1  one-cycle start pulse, already synchronised.
- Line_Num_In  in  8  line index, sampled when a request is accepted.
- Zone_Mask  in  4  enabled focal zones; bit z enables zone z.
- Pr_Gate  out  1  prepare window.
- RX_Gate  out  1  transmit/receive start window.
- End_Gate  out  1  end-of-firing window.
- Focus_Num  out  2  current zone.
- Line_Num  out  8  current line.
- Busy  out  1  a line sequence is in progress.
- Line_Done  out  1  one-cycle pulse after the last zone's END.
- Req_Dropped  out  1  one-cycle pulse when a request is rejected.
- Enable  out  1  front-end power enable; 1 = active.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-low.
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; pending flag 0.
- States: IDLE, PREP, FIRE, LISTEN, ENDW, NEXT.
- Phase counter cnt clears on PREP entry and increments every cycle until NEXT.
- Phase windows:
  - PREP while cnt < PR_CYCLES; Pr_Gate = 1.
  - FIRE while cnt < PR_CYCLES + RX_CYCLES; RX_Gate = 1.
  - LISTEN while cnt < PERIOD[z]; all gates 0.
  - ENDW while cnt < PERIOD[z] + END_CYCLES; End_Gate = 1.
  - NEXT: one cycle, all gates 0.
- At most one gate is high in any cycle.
- PERIODz must be ≥ PR_CYCLES + RX_CYCLES. Elaboration fails otherwise.
- Zone order: ascending index, skipping cleared Zone_Mask bits.
- Zone_Mask is sampled at acceptance and held for the whole line.
- Focus_Num updates on entry to PREP and is stable through ENDW.
- Accepting Line_Req in IDLE with sampled mask ≠ 0:
  - latch Line_Num_In and Zone_Mask;
  - Busy = 1 and Pr_Gate = 1 in cycle t+1, where t is the request cycle.
- Line_Req with Zone_Mask == 0: rejected; Req_Dropped pulses at t+1; state stays IDLE.
- Line_Req while Busy: stored in a single-deep pending slot, including its Line_Num_In and Zone_Mask.
- A further Line_Req while the slot is full: Req_Dropped pulses; the existing pending request is kept.
- NEXT when zones remain: go to PREP of the next zone.
- NEXT when no zones remain:
  - Line_Done pulses;
  - if pending, go directly to PREP with the pending line (Busy stays 1);
  - otherwise go to IDLE and Busy = 0.
- Line_Req in the same cycle as NEXT-with-no-zones-left: treated as pending, so the new line starts immediately.
- Enable (idle watchdog):
  - any Line_Req, accepted or not, reloads the idle counter and sets Enable = 1 next cycle;
  - Enable falls to 0 IDLE_CYCLES cycles after the last request;
  - the counter saturates and does not wrap.
- Reset mid-line: all gates drop to 0 on the next clock edge; the pending request is discarded.

Decomposition:
- Package ultra_seq_pkg holds:
  - the state enum;
  - the zone-period constant array built from PERIOD0..3;
  - a next-enabled-zone function: 4-bit mask plus current zone in, next zone and valid flag out.
- Sub-module idle_watchdog (counter plus Enable) is separate, so the top-level idle logic can reuse it.

Test Plan:
- Default parameters, Line_Req with mask 4'b0001, Line_Num_In = 8'd37:
  - Pr_Gate high for 3000 cycles, then RX_Gate for 250, gates low until cnt = 9000, End_Gate for 80, then Line_Done;
  - Line_Num = 37 and Focus_Num = 0 throughout.
- Mask 4'b1111: Focus_Num runs 0,1,2,3 with per-zone periods 9000/12000/18000/18000 (+80 end, +1 NEXT each); exactly one Line_Done.
- Mask 4'b1010: only zones 1 and 3 fire; no zone-0 or zone-2 gates appear.
- Requests during Busy:
  - request A starts a line; request B during zone 1 starts on the cycle after A's last NEXT, with Line_Done pulsing in that same NEXT cycle;
  - a third request C while B is pending gives Req_Dropped = 1, and C is never fired.
- Mask 4'b0000 in IDLE: Req_Dropped pulses and no gates assert.
- Enable timeout (IDLE_CYCLES overridden to 100): Enable drops at request + 101; RST_n = 0 mid-FIRE clears RX_Gate and Busy at the next edge.

Source files
------------

// File: rtl/ultra_seq_pkg.sv
// Shared types and helpers for the line firing sequencer: state encoding,
// zone-period table construction and enabled-zone search.
package ultra_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PREP   = 3'd1,
      ST_FIRE   = 3'd2,
      ST_LISTEN = 3'd3,
      ST_ENDW   = 3'd4,
      ST_NEXT   = 3'd5
   } state_t;

   localparam int NUM_ZONES   = 4;
   localparam int DEF_PERIOD0 = 9000;
   localparam int DEF_PERIOD1 = 12000;
   localparam int DEF_PERIOD2 = 18000;
   localparam int DEF_PERIOD3 = 18000;

   typedef logic [NUM_ZONES-1:0][31:0] period_arr_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] zone;
   } zone_sel_t;

   function automatic period_arr_t build_periods(input int p0, input int p1,
                                                 input int p2, input int p3);
      period_arr_t arr;
      arr[0] = 32'(p0);
      arr[1] = 32'(p1);
      arr[2] = 32'(p2);
      arr[3] = 32'(p3);
      return arr;
   endfunction

   // Lowest enabled zone strictly above cur; valid = 0 when none remains.
   function automatic zone_sel_t next_zone(input logic [3:0] mask, input logic [1:0] cur);
      zone_sel_t sel;
      sel.valid = 1'b0;
      sel.zone  = 2'd0;
      for (int z = NUM_ZONES - 1; z >= 0; z--) begin
         if ((z > int'(cur)) && mask[z]) begin
            sel.valid = 1'b1;
            sel.zone  = 2'(z);
         end
      end
      return sel;
   endfunction

   function automatic logic [1:0] first_zone(input logic [3:0] mask);
      zone_sel_t sel;
      sel = next_zone(mask, 2'd0);
      return mask[0] ? 2'd0 : sel.zone;
   endfunction

endpackage

// File: rtl/idle_watchdog.sv
// Holds the front-end enable high for a fixed number of cycles after the most
// recent kick; the counter saturates at the limit instead of wrapping.
module idle_watchdog #(
   parameter int CW          = 32,
   parameter int IDLE_CYCLES = 50000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic kick,
   output logic enable
);

   localparam logic [CW-1:0] LIMIT = CW'(IDLE_CYCLES);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          en_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (kick) begin
         cnt_nxt = '0;
      end else if (cnt < LIMIT) begin
         cnt_nxt = cnt + CW'(1);
      end else begin
         cnt_nxt = cnt;
      end
      en_nxt = kick || (cnt_nxt < LIMIT);
   end

   // Out of reset the counter sits at the limit so Enable stays low until a kick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= LIMIT;
         enable <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         enable <= en_nxt;
      end
   end

endmodule

// File: rtl/fire_scheduler.sv
// Line firing sequencer: walks the enabled focal zones of one imaging line
// through prepare / fire / listen / end windows, with a one-deep request queue.
module fire_scheduler
   import ultra_seq_pkg::*;
#(
   parameter int CW          = 32,
   parameter int PR_CYCLES   = 3000,
   parameter int RX_CYCLES   = 250,
   parameter int END_CYCLES  = 80,
   parameter int PERIOD0     = DEF_PERIOD0,
   parameter int PERIOD1     = DEF_PERIOD1,
   parameter int PERIOD2     = DEF_PERIOD2,
   parameter int PERIOD3     = DEF_PERIOD3,
   parameter int IDLE_CYCLES = 50000000
) (
   input  logic       CLK_100M,
   input  logic       RST_n,
   input  logic       Line_Req,
   input  logic [7:0] Line_Num_In,
   input  logic [3:0] Zone_Mask,
   output logic       Pr_Gate,
   output logic       RX_Gate,
   output logic       End_Gate,
   output logic [1:0] Focus_Num,
   output logic [7:0] Line_Num,
   output logic       Busy,
   output logic       Line_Done,
   output logic       Req_Dropped,
   output logic       Enable
);

   localparam int MIN_PERIOD = PR_CYCLES + RX_CYCLES;

   if ((PERIOD0 < MIN_PERIOD) || (PERIOD1 < MIN_PERIOD) ||
       (PERIOD2 < MIN_PERIOD) || (PERIOD3 < MIN_PERIOD)) begin : g_period_check
      $error("fire_scheduler: every zone period must cover the prepare and fire windows");
   end

   localparam period_arr_t   ZONE_PERIOD = build_periods(PERIOD0, PERIOD1, PERIOD2, PERIOD3);
   localparam logic [CW-1:0] PR_END      = CW'(PR_CYCLES);
   localparam logic [CW-1:0] RX_END      = CW'(MIN_PERIOD);
   localparam logic [CW-1:0] END_LEN     = CW'(END_CYCLES);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    zone, zone_nxt;
   logic [7:0]    line, line_nxt;
   logic [3:0]    mask, mask_nxt;
   logic          pend_valid, pend_valid_nxt;
   logic [7:0]    pend_line, pend_line_nxt;
   logic [3:0]    pend_mask, pend_mask_nxt;
   logic          done_s;
   logic          drop_s;
   logic          req_ok_s;
   logic          final_s;
   logic [CW-1:0] cnt_inc_s;
   logic [CW-1:0] period_s;
   logic [CW-1:0] endw_end_s;
   zone_sel_t     nz_s;
   logic [1:0]    first_in_s;
   logic [1:0]    first_pend_s;

   assign req_ok_s     = Line_Req && (Zone_Mask != 4'd0);
   assign cnt_inc_s    = cnt + CW'(1);
   assign period_s     = CW'(ZONE_PERIOD[zone]);
   assign endw_end_s   = period_s + END_LEN;
   assign nz_s         = next_zone(mask, zone);
   assign first_in_s   = first_zone(Zone_Mask);
   assign first_pend_s = first_zone(pend_mask);
   assign final_s      = (state == ST_NEXT) && !nz_s.valid;

   // Phase sequencing, zone stepping and pending-slot bookkeeping.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt_inc_s;
      zone_nxt       = zone;
      line_nxt       = line;
      mask_nxt       = mask;
      pend_valid_nxt = pend_valid;
      pend_line_nxt  = pend_line;
      pend_mask_nxt  = pend_mask;
      done_s         = 1'b0;
      drop_s         = 1'b0;

      case (state)
         ST_IDLE: begin
            cnt_nxt = cnt;
            if (req_ok_s) begin
               state_nxt = ST_PREP;
               cnt_nxt   = '0;
               line_nxt  = Line_Num_In;
               mask_nxt  = Zone_Mask;
               zone_nxt  = first_in_s;
            end else begin
               drop_s = Line_Req;
            end
         end
         ST_PREP: begin
            if (cnt_inc_s >= PR_END) begin
               state_nxt = ST_FIRE;
            end else begin
               state_nxt = ST_PREP;
            end
         end
         ST_FIRE: begin
            // A period equal to prepare+fire leaves no listen window at all.
            if (cnt_inc_s >= period_s) begin
               state_nxt = ST_ENDW;
            end else if (cnt_inc_s >= RX_END) begin
               state_nxt = ST_LISTEN;
            end else begin
               state_nxt = ST_FIRE;
            end
         end
         ST_LISTEN: begin
            if (cnt_inc_s >= period_s) begin
               state_nxt = ST_ENDW;
            end else begin
               state_nxt = ST_LISTEN;
            end
         end
         ST_ENDW: begin
            if (cnt_inc_s >= endw_end_s) begin
               state_nxt = ST_NEXT;
               done_s    = !nz_s.valid;
            end else begin
               state_nxt = ST_ENDW;
            end
         end
         ST_NEXT: begin
            cnt_nxt = '0;
            if (nz_s.valid) begin
               state_nxt = ST_PREP;
               zone_nxt  = nz_s.zone;
            end else if (pend_valid) begin
               state_nxt      = ST_PREP;
               line_nxt       = pend_line;
               mask_nxt       = pend_mask;
               zone_nxt       = first_pend_s;
               pend_valid_nxt = 1'b0;
            end else if (req_ok_s) begin
               state_nxt = ST_PREP;
               line_nxt  = Line_Num_In;
               mask_nxt  = Zone_Mask;
               zone_nxt  = first_in_s;
            end else begin
               state_nxt = ST_IDLE;
               cnt_nxt   = cnt;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase

      // Requests arriving mid-line park in the slot; a request on the final NEXT
      // with an empty slot was already started directly above.
      if ((state != ST_IDLE) && Line_Req) begin
         if (!req_ok_s || pend_valid) begin
            drop_s = 1'b1;
         end else if (!final_s) begin
            pend_valid_nxt = 1'b1;
            pend_line_nxt  = Line_Num_In;
            pend_mask_nxt  = Zone_Mask;
         end else begin
            pend_valid_nxt = 1'b0;
         end
      end else begin
         drop_s = drop_s;
      end
   end

   // State, phase counter, latched line context and registered outputs.
   always_ff @(posedge CLK_100M) begin
      if (!RST_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         zone        <= 2'd0;
         line        <= 8'd0;
         mask        <= 4'd0;
         pend_valid  <= 1'b0;
         pend_line   <= 8'd0;
         pend_mask   <= 4'd0;
         Pr_Gate     <= 1'b0;
         RX_Gate     <= 1'b0;
         End_Gate    <= 1'b0;
         Focus_Num   <= 2'd0;
         Line_Num    <= 8'd0;
         Busy        <= 1'b0;
         Line_Done   <= 1'b0;
         Req_Dropped <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         zone        <= zone_nxt;
         line        <= line_nxt;
         mask        <= mask_nxt;
         pend_valid  <= pend_valid_nxt;
         pend_line   <= pend_line_nxt;
         pend_mask   <= pend_mask_nxt;
         Pr_Gate     <= (state_nxt == ST_PREP);
         RX_Gate     <= (state_nxt == ST_FIRE);
         End_Gate    <= (state_nxt == ST_ENDW);
         Focus_Num   <= zone_nxt;
         Line_Num    <= line_nxt;
         Busy        <= (state_nxt != ST_IDLE);
         Line_Done   <= done_s;
         Req_Dropped <= drop_s;
      end
   end

   idle_watchdog #(
      .CW          (CW),
      .IDLE_CYCLES (IDLE_CYCLES)
   ) u_idle_watchdog (
      .clk    (CLK_100M),
      .rst_n  (RST_n),
      .kick   (Line_Req),
      .enable (Enable)
   );

endmodule

// File: tb/tb_fire_scheduler.sv
// Scoreboard bench for fire_scheduler: a timeline model schedules firings,
// line completions and drops; a negedge monitor checks what the DUT presents.
module tb_fire_scheduler;

   localparam int PR   = 30;
   localparam int RX   = 10;
   localparam int EN   = 8;
   localparam int IDLE = 100;
   localparam int P0   = 90;
   localparam int P1   = 120;
   localparam int P2   = 60;
   localparam int P3   = 40;

   logic       clk = 1'b0;
   logic       RST_n;
   logic       Line_Req;
   logic [7:0] Line_Num_In;
   logic [3:0] Zone_Mask;
   logic       Pr_Gate, RX_Gate, End_Gate, Busy, Line_Done, Req_Dropped, Enable;
   logic [1:0] Focus_Num;
   logic [7:0] Line_Num;

   fire_scheduler #(
      .CW(32), .PR_CYCLES(PR), .RX_CYCLES(RX), .END_CYCLES(EN),
      .PERIOD0(P0), .PERIOD1(P1), .PERIOD2(P2), .PERIOD3(P3), .IDLE_CYCLES(IDLE)
   ) dut (
      .CLK_100M(clk), .RST_n(RST_n), .Line_Req(Line_Req), .Line_Num_In(Line_Num_In),
      .Zone_Mask(Zone_Mask), .Pr_Gate(Pr_Gate), .RX_Gate(RX_Gate), .End_Gate(End_Gate),
      .Focus_Num(Focus_Num), .Line_Num(Line_Num), .Busy(Busy), .Line_Done(Line_Done),
      .Req_Dropped(Req_Dropped), .Enable(Enable)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int t; int line; int zone; } fire_t;
   typedef struct { int t; int line; } done_t;

   fire_t fq[$];
   done_t dq[$];
   int    drq[$];

   int last_end    = -10;
   int pend_start  = -10;
   int chain_start = -10;
   int last_req    = -1000;
   int prev_req    = -1000;
   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   function automatic int per(int z);
      case (z)
         0: return P0;
         1: return P1;
         2: return P2;
         default: return P3;
      endcase
   endfunction

   task automatic check(string name, int got, int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, got, exp);
      end
   endtask

   task automatic note_fail(string name, int got, int exp);
      total++;
      bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, got, exp);
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Lay out one line on the timeline: zones back to back, each costing period+end+next.
   task automatic schedule(int start, int line, logic [3:0] mask);
      int t = start;
      for (int z = 0; z < 4; z++) begin
         if (mask[z]) begin
            fq.push_back('{t: t, line: line, zone: z});
            t += per(z) + EN + 1;
         end
      end
      dq.push_back('{t: t - 1, line: line});
      last_end = t - 1;
   endtask

   task automatic request(int line, logic [3:0] mask);
      int t = cyc;
      Line_Req    = 1'b1;
      Line_Num_In = 8'(line);
      Zone_Mask   = mask;
      prev_req    = last_req;
      last_req    = t;
      if (mask == 4'd0) begin
         drq.push_back(t + 1);
      end else if (t > last_end) begin
         chain_start = t + 1;
         schedule(t + 1, line, mask);
      end else if (t < pend_start) begin
         drq.push_back(t + 1);
      end else begin
         pend_start = last_end + 1;
         schedule(last_end + 1, line, mask);
      end
      step(1);
      Line_Req = 1'b0;
   endtask

   task automatic wait_idle();
      int n = last_end - cyc + 3;
      if (n < 1) n = 1;
      if (n > 5000) begin
         note_fail("wait_budget", n, 5000);
         n = 5000;
      end
      step(n);
   endtask

   fire_t act;
   bit    act_v   = 1'b0;
   logic  prev_pr = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         int    o;
         int    pz;
         int    r;
         bit    ep, er, ee, eb, een;
         done_t d;
         ep = 1'b0; er = 1'b0; ee = 1'b0;
         if (Pr_Gate && !prev_pr) begin
            if (fq.size() == 0) begin
               note_fail("prep_unexpected", cyc, -1);
            end else begin
               act   = fq.pop_front();
               act_v = 1'b1;
               check("prep_start", cyc, act.t);
            end
         end
         while (fq.size() > 0 && fq[0].t < cyc) begin
            note_fail("prep_missing", cyc, fq[0].t);
            void'(fq.pop_front());
         end
         if (act_v) begin
            o  = cyc - act.t;
            pz = per(act.zone);
            if (o >= 0 && o < pz + EN) begin
               ep = (o < PR);
               er = (o >= PR) && (o < PR + RX);
               ee = (o >= pz);
               check("focus_num", int'(Focus_Num), act.zone);
               check("line_num", int'(Line_Num), act.line);
            end
         end
         check("pr_gate", int'(Pr_Gate), int'(ep));
         check("rx_gate", int'(RX_Gate), int'(er));
         check("end_gate", int'(End_Gate), int'(ee));
         prev_pr = Pr_Gate;

         if (Line_Done) begin
            if (dq.size() == 0) begin
               note_fail("done_unexpected", cyc, -1);
            end else begin
               d = dq.pop_front();
               check("done_cycle", cyc, d.t);
               check("done_line", int'(Line_Num), d.line);
            end
         end
         while (dq.size() > 0 && dq[0].t < cyc) begin
            note_fail("done_missing", cyc, dq[0].t);
            void'(dq.pop_front());
         end

         if (Req_Dropped) begin
            if (drq.size() == 0) note_fail("drop_unexpected", cyc, -1);
            else check("drop_cycle", cyc, drq.pop_front());
         end
         while (drq.size() > 0 && drq[0] < cyc) begin
            note_fail("drop_missing", cyc, drq[0]);
            void'(drq.pop_front());
         end

         eb = (cyc >= chain_start) && (cyc <= last_end);
         check("busy", int'(Busy), int'(eb));
         r   = (last_req < cyc) ? last_req : prev_req;
         een = (cyc - r >= 1) && (cyc - r <= IDLE);
         check("enable", int'(Enable), int'(een));
      end
   end

   task automatic check_all_zero(string tag);
      check({tag, "_pr"}, int'(Pr_Gate), 0);
      check({tag, "_rx"}, int'(RX_Gate), 0);
      check({tag, "_end"}, int'(End_Gate), 0);
      check({tag, "_busy"}, int'(Busy), 0);
      check({tag, "_focus"}, int'(Focus_Num), 0);
      check({tag, "_line"}, int'(Line_Num), 0);
      check({tag, "_done"}, int'(Line_Done), 0);
      check({tag, "_drop"}, int'(Req_Dropped), 0);
      check({tag, "_enable"}, int'(Enable), 0);
   endtask

   task automatic model_reset();
      fq.delete();
      dq.delete();
      drq.delete();
      last_end    = -10;
      pend_start  = -10;
      chain_start = -10;
      last_req    = -1000;
      prev_req    = -1000;
      act_v       = 1'b0;
      prev_pr     = 1'b0;
   endtask

   initial begin
      int t0;
      int aend;
      RST_n       = 1'b0;
      Line_Req    = 1'b0;
      Line_Num_In = 8'd0;
      Zone_Mask   = 4'd0;
      step(3);
      check_all_zero("reset");
      RST_n  = 1'b1;
      chk_en = 1'b1;
      step(2);

      request(37, 4'b0001); wait_idle();
      request(5, 4'b1111);  wait_idle();
      request(9, 4'b1010);  wait_idle();
      request(0, 4'b0000);  step(3);

      // A starts, B parks during zone 1, C is refused while B waits.
      request(11, 4'b0011);
      step(P0 + EN + 1 + 4);
      request(12, 4'b0101);
      step(3);
      request(13, 4'b1111);
      wait_idle();

      // Request landing exactly on the final NEXT with the slot empty.
      request(20, 4'b0100);
      step(last_end - cyc);
      request(21, 4'b1000);
      wait_idle();

      // Request on the final NEXT while the slot is already full.
      request(30, 4'b0001);
      aend = last_end;
      step(2);
      request(31, 4'b0010);
      step(aend - cyc);
      request(32, 4'b0001);
      wait_idle();

      // Enable holds for IDLE cycles after a request, then drops.
      step(IDLE + 5);
      t0 = cyc;
      request(40, 4'b0000);
      step(t0 + IDLE - cyc);
      check("enable_last_high", int'(Enable), 1);
      step(1);
      check("enable_dropped", int'(Enable), 0);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 29) == 0) request($urandom_range(0, 255), 4'($urandom_range(0, 15)));
         else step(1);
      end
      wait_idle();

      // Reset in the middle of a fire window.
      request(50, 4'b0110);
      step(PR + 2);
      check("rx_before_reset", int'(RX_Gate), 1);
      chk_en = 1'b0;
      RST_n  = 1'b0;
      step(1);
      check_all_zero("midreset");
      RST_n = 1'b1;
      model_reset();
      chk_en = 1'b1;
      step(3);
      request(60, 4'b0001);
      wait_idle();

      check("left_fire", fq.size(), 0);
      check("left_done", dq.size(), 0);
      check("left_drop", drq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
